// File: rtl/plate_boarder_detect_if.sv
// Bundles the binarised pixel stream and the plate-box result into one interface.
// Both sides use the same signals, but each modport gives them opposite directions.
//   per_frame_vsync  frame sync; a rising edge marks the start of a frame
//   per_frame_href   line valid
//   per_frame_clken  pixel valid strobe
//   per_frame_bit    binarised pixel, 1 = white
//   plate_boarder_*  box of the last completed frame (up/down rows, left/right columns)
//   plate_exist_flag the box of the last completed frame is valid
//   result_valid     one-cycle pulse when the outputs update
// master: the pixel source, which also consumes the result.
// slave : the detector.
interface plate_boarder_detect_if;
    logic       per_frame_vsync;
    logic       per_frame_href;
    logic       per_frame_clken;
    logic       per_frame_bit;
    logic [9:0] plate_boarder_up;
    logic [9:0] plate_boarder_down;
    logic [9:0] plate_boarder_left;
    logic [9:0] plate_boarder_right;
    logic       plate_exist_flag;
    logic       result_valid;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_frame_bit,
        input  plate_boarder_up, plate_boarder_down, plate_boarder_left,
               plate_boarder_right, plate_exist_flag, result_valid
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_frame_bit,
        output plate_boarder_up, plate_boarder_down, plate_boarder_left,
               plate_boarder_right, plate_exist_flag, result_valid
    );
endinterface

// File: rtl/plate_boarder_detect.sv
// plate_boarder_detect: finds the licence-plate bounding box in a binarised video stream.
// A row qualifies when it contains at least ROW_TH white pixels inside the active area.
// The detector merges all qualifying rows of a frame into a single box. At the next
// frame start it latches that box for the downstream grid-overlay stage, so the
// result stays stable for the whole following frame.
// Ports:
//   clk    pixel clock
//   rst_n  synchronous active-low reset
//   bus    slave modport of plate_boarder_detect_if (pixel stream in, box result out)
module plate_boarder_detect #(
    parameter logic [9:0] IMG_WIDTH  = 10'd640,
    parameter logic [9:0] IMG_HEIGHT = 10'd480,
    parameter logic [9:0] ROW_TH     = 10'd20,
    parameter logic [9:0] MIN_ROWS   = 10'd10,
    parameter logic [9:0] MIN_WIDTH  = 10'd40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    plate_boarder_detect_if.slave        bus
);

    localparam logic [9:0] CNT_MAX = 10'h3FF;

    // Input edge detection.
    logic       vsync_q, vsync_d;
    logic       href_q, href_d;

    // Position and per-row statistics.
    logic [9:0] x_cnt_q, x_cnt_d;
    logic [9:0] y_cnt_q, y_cnt_d;
    logic [9:0] row_cnt_q, row_cnt_d;
    logic [9:0] row_min_q, row_min_d;
    logic [9:0] row_max_q, row_max_d;

    // Per-frame box accumulators.
    logic       any_qual_q, any_qual_d;
    logic [9:0] qual_rows_q, qual_rows_d;
    logic [9:0] up_acc_q, up_acc_d;
    logic [9:0] down_acc_q, down_acc_d;
    logic [9:0] left_acc_q, left_acc_d;
    logic [9:0] right_acc_q, right_acc_d;

    // Latched results.
    logic [9:0] up_q, up_d;
    logic [9:0] down_q, down_d;
    logic [9:0] left_q, left_d;
    logic [9:0] right_q, right_d;
    logic       exist_q, exist_d;
    logic       valid_q, valid_d;

    logic        vs_rise;
    logic        row_end;
    logic        pix_in_area;
    logic [10:0] box_width;
    logic        exist_now;

    always_comb begin
        vs_rise = bus.per_frame_vsync & ~vsync_q;
        row_end = ~bus.per_frame_href & href_q;

        pix_in_area = (x_cnt_q < IMG_WIDTH) && (y_cnt_q < IMG_HEIGHT);

        // The subtraction is 11 bits wide, so an empty box (left=1023, right=0)
        // cannot alias to a small width. any_qual also gates that case.
        box_width = {1'b0, right_acc_q} - {1'b0, left_acc_q} + 11'd1;
        exist_now = any_qual_q && (qual_rows_q >= MIN_ROWS) &&
                    (box_width >= {1'b0, MIN_WIDTH});

        vsync_d     = bus.per_frame_vsync;
        href_d      = bus.per_frame_href;
        x_cnt_d     = x_cnt_q;
        y_cnt_d     = y_cnt_q;
        row_cnt_d   = row_cnt_q;
        row_min_d   = row_min_q;
        row_max_d   = row_max_q;
        any_qual_d  = any_qual_q;
        qual_rows_d = qual_rows_q;
        up_acc_d    = up_acc_q;
        down_acc_d  = down_acc_q;
        left_acc_d  = left_acc_q;
        right_acc_d = right_acc_q;
        up_d        = up_q;
        down_d      = down_q;
        left_d      = left_q;
        right_d     = right_q;
        exist_d     = exist_q;
        valid_d     = vs_rise;

        if (vs_rise) begin
            // Frame start has priority. A pixel or a row end in this same
            // cycle belongs to the frame that is being closed, so it is dropped.
            exist_d = exist_now;
            if (exist_now) begin
                up_d    = up_acc_q;
                down_d  = down_acc_q;
                left_d  = left_acc_q;
                right_d = right_acc_q;
            end
            x_cnt_d     = 10'd0;
            y_cnt_d     = 10'd0;
            row_cnt_d   = 10'd0;
            row_min_d   = CNT_MAX;
            row_max_d   = 10'd0;
            any_qual_d  = 1'b0;
            qual_rows_d = 10'd0;
            up_acc_d    = 10'd0;
            down_acc_d  = 10'd0;
            left_acc_d  = CNT_MAX;
            right_acc_d = 10'd0;
        end else begin
            // Pixel accumulation and row end are mutually exclusive, because
            // href is high for a pixel and low for a row end.
            if (bus.per_frame_clken && bus.per_frame_href) begin
                if (pix_in_area && bus.per_frame_bit) begin
                    if (row_cnt_q != CNT_MAX) row_cnt_d = row_cnt_q + 10'd1;
                    if (x_cnt_q < row_min_q)  row_min_d = x_cnt_q;
                    if (x_cnt_q > row_max_q)  row_max_d = x_cnt_q;
                end
                if (x_cnt_q != CNT_MAX) x_cnt_d = x_cnt_q + 10'd1;
            end

            if (row_end) begin
                if ((row_cnt_q >= ROW_TH) && (y_cnt_q < IMG_HEIGHT)) begin
                    if (!any_qual_q) up_acc_d = y_cnt_q;
                    down_acc_d = y_cnt_q;
                    if (row_min_q < left_acc_q)  left_acc_d  = row_min_q;
                    if (row_max_q > right_acc_q) right_acc_d = row_max_q;
                    if (qual_rows_q != CNT_MAX)  qual_rows_d = qual_rows_q + 10'd1;
                    any_qual_d = 1'b1;
                end
                row_cnt_d = 10'd0;
                row_min_d = CNT_MAX;
                row_max_d = 10'd0;
                x_cnt_d   = 10'd0;
                if (y_cnt_q != CNT_MAX) y_cnt_d = y_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            x_cnt_q     <= 10'd0;
            y_cnt_q     <= 10'd0;
            row_cnt_q   <= 10'd0;
            row_min_q   <= CNT_MAX;
            row_max_q   <= 10'd0;
            any_qual_q  <= 1'b0;
            qual_rows_q <= 10'd0;
            up_acc_q    <= 10'd0;
            down_acc_q  <= 10'd0;
            left_acc_q  <= CNT_MAX;
            right_acc_q <= 10'd0;
            up_q        <= 10'd0;
            down_q      <= 10'd0;
            left_q      <= 10'd0;
            right_q     <= 10'd0;
            exist_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            row_cnt_q   <= row_cnt_d;
            row_min_q   <= row_min_d;
            row_max_q   <= row_max_d;
            any_qual_q  <= any_qual_d;
            qual_rows_q <= qual_rows_d;
            up_acc_q    <= up_acc_d;
            down_acc_q  <= down_acc_d;
            left_acc_q  <= left_acc_d;
            right_acc_q <= right_acc_d;
            up_q        <= up_d;
            down_q      <= down_d;
            left_q      <= left_d;
            right_q     <= right_d;
            exist_q     <= exist_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.plate_boarder_up    = up_q;
    assign bus.plate_boarder_down  = down_q;
    assign bus.plate_boarder_left  = left_q;
    assign bus.plate_boarder_right = right_q;
    assign bus.plate_exist_flag    = exist_q;
    assign bus.result_valid        = valid_q;

endmodule
